// File: rtl/usb_pkg.sv
// Shared types and constants for the USB host-facing line transmitter.
package usb_pkg;

  localparam logic [7:0]  SYNC_BYTE   = 8'h80;
  localparam int unsigned EOP_SE0_LEN = 2;
  localparam logic [1:0]  LS_SE0      = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_e;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } tx_byte_t;

  // {dp,dm} idle/J and K states; low-speed swaps the pair polarity
  function automatic logic [1:0] ls_j(input bit low_speed);
    return low_speed ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] ls_k(input bit low_speed);
    return low_speed ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/usb_line_tx_if.sv
// Byte handshake between the hub packet layer and the line transmitter.
interface usb_line_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;

  modport master (output tx_valid, output tx_data, output tx_last, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input tx_last, output tx_ready);
endinterface

// File: rtl/usb_nrzi_stuffer.sv
// NRZI level register, consecutive-ones counter and registered {dp,dm} line state.
module usb_nrzi_stuffer
  import usb_pkg::*;
#(
  parameter bit          LOW_SPEED = 1'b0,
  parameter int unsigned STUFF_LEN = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       bit_i,
  input  logic       bit_valid_i,
  input  logic       se0_i,
  input  logic       restart_i,
  output logic [1:0] line_o,
  output logic       stuff_now_o
);

  localparam int unsigned CNT_W = $clog2(STUFF_LEN + 1);
  localparam logic [1:0]  LS_J  = ls_j(LOW_SPEED);
  localparam logic [1:0]  LS_K  = ls_k(LOW_SPEED);

  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       line_q, line_d;

  // level 0 = J, 1 = K; a 0 bit toggles, a 1 bit holds
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    line_d  = level_q ? LS_K : LS_J;
    if (restart_i) begin
      level_d = 1'b0;
      cnt_d   = '0;
      line_d  = LS_J;
    end else if (se0_i) begin
      line_d = LS_SE0;
    end else if (bit_valid_i) begin
      level_d = bit_i ? level_q : ~level_q;
      cnt_d   = bit_i ? cnt_q + CNT_W'(1) : '0;
      line_d  = level_d ? LS_K : LS_J;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      line_q  <= LS_J;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
    end
  end

  assign line_o      = line_q;
  assign stuff_now_o = (cnt_q == CNT_W'(STUFF_LEN));

endmodule

// File: rtl/usb_line_tx.sv
// Byte-level transmit FSM: SYNC, LSB-first data with bit stuffing, EOP, and the byte handshake.
module usb_line_tx
  import usb_pkg::*;
#(
  parameter bit          LOW_SPEED = 1'b0,
  parameter int unsigned STUFF_LEN = 6
) (
  input  logic          low_clock,
  input  logic          reset,
  usb_line_tx_if.slave  tx_if,
  output logic          tx_dp,
  output logic          tx_dm,
  output logic          tx_oe,
  output logic          tx_busy,
  output logic          tx_underrun
);

  tx_state_e  state_q, state_d;
  logic [2:0] idx_q, idx_d;
  tx_byte_t   byte_q, byte_d;
  logic       eop_pend_q, eop_pend_d;
  logic       oe_q;

  logic       bit_c, bit_valid_c, se0_c, restart_c;
  logic       ready_c, underrun_c, eop_c, stuff_now;
  logic [1:0] line;

  // state_q names what is on the line this cycle; the bit chosen here appears next cycle
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    eop_pend_d  = eop_pend_q;
    bit_c       = 1'b0;
    bit_valid_c = 1'b0;
    se0_c       = 1'b0;
    restart_c   = 1'b0;
    ready_c     = 1'b0;
    underrun_c  = 1'b0;
    eop_c       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (tx_if.tx_valid) begin
          byte_d      = '{last: tx_if.tx_last, data: tx_if.tx_data};
          state_d     = ST_SYNC;
          idx_d       = '0;
          bit_c       = SYNC_BYTE[0];
          bit_valid_c = 1'b1;
        end
      end
      ST_SYNC: begin
        bit_valid_c = 1'b1;
        if (idx_q == 3'd7) begin
          state_d = ST_DATA;
          idx_d   = '0;
          bit_c   = byte_q.data[0];
        end else begin
          idx_d = idx_q + 3'd1;
          bit_c = SYNC_BYTE[idx_d];
        end
      end
      ST_DATA: begin
        if (idx_q != 3'd7) begin
          idx_d = idx_q + 3'd1;
        end else begin
          idx_d = '0;
          if (!byte_q.last) begin
            ready_c = 1'b1;
            if (tx_if.tx_valid) begin
              byte_d = '{last: tx_if.tx_last, data: tx_if.tx_data};
            end else begin
              underrun_c = 1'b1;
              eop_c      = 1'b1;
            end
          end else begin
            eop_c = 1'b1;
          end
        end
        // a pending stuff bit always goes ahead of the next data bit or EOP
        if (stuff_now) begin
          state_d     = ST_STUFF;
          eop_pend_d  = eop_c;
          bit_valid_c = 1'b1;
        end else if (eop_c) begin
          state_d = ST_EOP_SE0;
          se0_c   = 1'b1;
        end else begin
          bit_c       = byte_d.data[idx_d];
          bit_valid_c = 1'b1;
        end
      end
      ST_STUFF: begin
        if (eop_pend_q) begin
          state_d = ST_EOP_SE0;
          idx_d   = '0;
          se0_c   = 1'b1;
        end else begin
          state_d     = ST_DATA;
          bit_c       = byte_q.data[idx_q];
          bit_valid_c = 1'b1;
        end
      end
      ST_EOP_SE0: begin
        if (idx_q == 3'(EOP_SE0_LEN - 1)) begin
          state_d   = ST_EOP_J;
          restart_c = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
          se0_c = 1'b1;
        end
      end
      ST_EOP_J: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge low_clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      byte_q     <= '0;
      eop_pend_q <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      byte_q     <= byte_d;
      eop_pend_q <= eop_pend_d;
      oe_q       <= (state_d != ST_IDLE);
    end
  end

  usb_nrzi_stuffer #(
    .LOW_SPEED (LOW_SPEED),
    .STUFF_LEN (STUFF_LEN)
  ) u_nrzi (
    .clk_i       (low_clock),
    .rst_i       (reset),
    .bit_i       (bit_c),
    .bit_valid_i (bit_valid_c),
    .se0_i       (se0_c),
    .restart_i   (restart_c),
    .line_o      (line),
    .stuff_now_o (stuff_now)
  );

  assign tx_if.tx_ready = ready_c & ~reset;
  assign tx_underrun    = underrun_c & ~reset;
  assign tx_dp          = line[1];
  assign tx_dm          = line[0];
  assign tx_oe          = oe_q;
  assign tx_busy        = oe_q;

endmodule
